// File: rtl/fetch_packet_sender_if.sv
// rtl/fetch_packet_sender_if.sv - I-cache request/response and IQ write bundle for the fetch packet sender
interface fetch_packet_sender_if #(
    parameter int CP_W = 8
);
    logic                flush_i;
    logic [31:0]         flushTarget_i;
    logic                stopFetch_i;
    logic                icReq_o;
    logic [31:0]         icAddr_o;
    logic                icAddrOk_i;
    logic                icDataOk_i;
    logic [127:0]        icData_i;
    logic                icHasExc_i;
    logic [4:0]          icExcCode_i;
    logic                icRefill_i;
    logic [3:0]          bpTake_i;
    logic [127:0]        bpDest_i;
    logic [4*CP_W-1:0]   bpInfo_i;
    logic                IF_valid_o;
    logic [3:0]          IF_instEnable_o;
    logic [2:0]          IF_instNum_o;
    logic [31:0]         IF_instBasePC_o;
    logic [127:0]        IF_inst_p_o;
    logic [127:0]        IF_predDest_p_o;
    logic [3:0]          IF_predTake_p_o;
    logic [4*CP_W-1:0]   IF_predInfo_p_o;
    logic                IF_hasException_o;
    logic [4:0]          IF_ExcCode_o;
    logic                IF_isRefill_o;

    modport master (
        input  flush_i, flushTarget_i, stopFetch_i,
        input  icAddrOk_i, icDataOk_i, icData_i, icHasExc_i, icExcCode_i, icRefill_i,
        input  bpTake_i, bpDest_i, bpInfo_i,
        output icReq_o, icAddr_o,
        output IF_valid_o, IF_instEnable_o, IF_instNum_o, IF_instBasePC_o,
        output IF_inst_p_o, IF_predDest_p_o, IF_predTake_p_o, IF_predInfo_p_o,
        output IF_hasException_o, IF_ExcCode_o, IF_isRefill_o
    );

    modport slave (
        output flush_i, flushTarget_i, stopFetch_i,
        output icAddrOk_i, icDataOk_i, icData_i, icHasExc_i, icExcCode_i, icRefill_i,
        output bpTake_i, bpDest_i, bpInfo_i,
        input  icReq_o, icAddr_o,
        input  IF_valid_o, IF_instEnable_o, IF_instNum_o, IF_instBasePC_o,
        input  IF_inst_p_o, IF_predDest_p_o, IF_predTake_p_o, IF_predInfo_p_o,
        input  IF_hasException_o, IF_ExcCode_o, IF_isRefill_o
    );
endinterface

// File: rtl/fetch_packet_sender.sv
// rtl/fetch_packet_sender.sv - fetch PC holder, I-cache requester and IQ packet builder
module fetch_packet_sender #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          CP_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_packet_sender_if.master  bus
);
    typedef enum logic [1:0] {REQ, WAIT, DROP, HALT} state_t;

    state_t             state;
    logic [31:0]        pc;
    logic               pkt_valid;
    logic               ds_pending;
    logic [31:0]        ds_target;

    logic [3:0]         pkt_enable;
    logic [2:0]         pkt_num;
    logic [31:0]        pkt_base;
    logic [127:0]       pkt_inst;
    logic [127:0]       pkt_dest;
    logic [3:0]         pkt_take;
    logic [4*CP_W-1:0]  pkt_info;
    logic               pkt_exc;
    logic [4:0]         pkt_code;
    logic               pkt_refill;

    logic               consumed;
    logic               can_issue;
    logic               req_fire;

    logic [1:0]         off;
    logic [2:0]         raw_n;
    logic [127:0]       al_inst;
    logic [127:0]       al_dest;
    logic [3:0]         al_take;
    logic [4*CP_W-1:0]  al_info;
    logic               tk_found;
    logic [1:0]         tk_idx;
    logic [2:0]         b_count;
    logic [31:0]        b_next;
    logic               b_ds;
    logic [31:0]        b_ds_tgt;
    logic [3:0]         b_take;

    assign consumed  = pkt_valid & ~bus.stopFetch_i & ~bus.flush_i;
    assign can_issue = ~pkt_valid | consumed;
    assign bus.icReq_o  = rst & (state == REQ) & (pc[1:0] == 2'b00) & can_issue;
    assign bus.icAddr_o = {pc[31:4], 4'b0000};
    assign req_fire  = bus.icReq_o & bus.icAddrOk_i;

    assign bus.IF_valid_o        = pkt_valid & ~bus.stopFetch_i & ~bus.flush_i;
    assign bus.IF_instEnable_o   = pkt_enable;
    assign bus.IF_instNum_o      = pkt_num;
    assign bus.IF_instBasePC_o   = pkt_base;
    assign bus.IF_inst_p_o       = pkt_inst;
    assign bus.IF_predDest_p_o   = pkt_dest;
    assign bus.IF_predTake_p_o   = pkt_take;
    assign bus.IF_predInfo_p_o   = pkt_info;
    assign bus.IF_hasException_o = pkt_exc;
    assign bus.IF_ExcCode_o      = pkt_code;
    assign bus.IF_isRefill_o     = pkt_refill;

    // Shift the returned group down so aligned slot 0 is the word at the fetch PC
    assign off     = pc[3:2];
    assign raw_n   = 3'd4 - {1'b0, off};
    assign al_inst = bus.icData_i >> {off, 5'b00000};
    assign al_dest = bus.bpDest_i >> {off, 5'b00000};
    assign al_take = bus.bpTake_i >> off;
    assign al_info = bus.bpInfo_i >> (CP_W * int'(off));

    // Truncate after the first predicted-taken branch plus its delay slot
    always_comb begin
        tk_found = 1'b0;
        tk_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (al_take[i]) begin
                tk_found = 1'b1;
                tk_idx   = 2'(i);
            end
        end
        b_count  = raw_n;
        b_next   = {pc[31:4] + 28'd1, 4'b0000};
        b_ds     = 1'b0;
        b_ds_tgt = ds_target;
        b_take   = al_take;
        if (ds_pending) begin
            b_count = 3'd1;
            b_next  = ds_target;
            b_take  = 4'b0000;
        end else if (tk_found) begin
            if ({1'b0, tk_idx} + 3'd1 < raw_n) begin
                b_count = {1'b0, tk_idx} + 3'd2;
                b_next  = al_dest[{tk_idx, 5'b00000} +: 32];
            end else begin
                b_ds     = 1'b1;
                b_ds_tgt = al_dest[{tk_idx, 5'b00000} +: 32];
            end
        end
        if (bus.icHasExc_i) begin
            b_count = 3'd1;
            b_ds    = 1'b0;
        end
    end

    function automatic logic [3:0] therm(input logic [2:0] cnt);
        case (cnt)
            3'd1:    therm = 4'b0001;
            3'd2:    therm = 4'b0011;
            3'd3:    therm = 4'b0111;
            default: therm = 4'b1111;
        endcase
    endfunction

    // Fetch FSM, PC update and registered packet fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            pkt_valid  <= 1'b0;
            ds_pending <= 1'b0;
            ds_target  <= 32'd0;
            pkt_enable <= 4'd0;
            pkt_num    <= 3'd0;
            pkt_base   <= 32'd0;
            pkt_inst   <= '0;
            pkt_dest   <= '0;
            pkt_take   <= 4'd0;
            pkt_info   <= '0;
            pkt_exc    <= 1'b0;
            pkt_code   <= 5'd0;
            pkt_refill <= 1'b0;
        end else if (bus.flush_i) begin
            pc         <= bus.flushTarget_i;
            pkt_valid  <= 1'b0;
            ds_pending <= 1'b0;
            // A still-outstanding response must be swallowed before the next request
            if ((state == WAIT && !bus.icDataOk_i) || (state == DROP && !bus.icDataOk_i) ||
                (state == REQ && req_fire))
                state <= DROP;
            else
                state <= REQ;
        end else begin
            if (consumed)
                pkt_valid <= 1'b0;
            case (state)
                REQ: begin
                    if (pc[1:0] != 2'b00) begin
                        if (can_issue) begin
                            pkt_valid  <= 1'b1;
                            pkt_enable <= 4'b0001;
                            pkt_num    <= 3'd1;
                            pkt_base   <= pc;
                            pkt_inst   <= '0;
                            pkt_dest   <= '0;
                            pkt_take   <= 4'd0;
                            pkt_info   <= '0;
                            pkt_exc    <= 1'b1;
                            pkt_code   <= 5'h04;
                            pkt_refill <= 1'b0;
                            state      <= HALT;
                        end
                    end else if (req_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.icDataOk_i) begin
                        pkt_valid  <= 1'b1;
                        pkt_enable <= therm(b_count);
                        pkt_num    <= b_count;
                        pkt_base   <= pc;
                        pkt_inst   <= al_inst;
                        pkt_dest   <= al_dest;
                        pkt_take   <= b_take;
                        pkt_info   <= al_info;
                        pkt_exc    <= bus.icHasExc_i;
                        pkt_code   <= bus.icHasExc_i ? bus.icExcCode_i : 5'd0;
                        pkt_refill <= bus.icHasExc_i & bus.icRefill_i;
                        ds_pending <= b_ds;
                        ds_target  <= b_ds_tgt;
                        if (bus.icHasExc_i) begin
                            state <= HALT;
                        end else begin
                            pc    <= b_next;
                            state <= REQ;
                        end
                    end
                end
                DROP: begin
                    if (bus.icDataOk_i)
                        state <= REQ;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_packet_sender.sv
// tb/tb_fetch_packet_sender.sv - directed self-checking bench for fetch_packet_sender
module tb_fetch_packet_sender;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    fetch_packet_sender_if #(.CP_W(8)) bus();

    fetch_packet_sender #(.RESET_PC(32'hBFC0_0000), .CP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flush_to(input logic [31:0] tgt);
        bus.flush_i       = 1'b1;
        bus.flushTarget_i = tgt;
        tick();
        bus.flush_i       = 1'b0;
    endtask

    task automatic fetch(input logic [127:0] data, input logic [3:0] take, input logic [127:0] dest,
                         input logic exc, input logic [4:0] code, input logic refill,
                         output logic [31:0] addr);
        int n;
        n = 0;
        while (!bus.icReq_o && n < 20) begin
            tick();
            n++;
        end
        addr = bus.icAddr_o;
        if (!bus.icReq_o) begin
            chk("req_timeout", 128'(bus.icReq_o), 128'd1);
        end else begin
            bus.icAddrOk_i = 1'b1;
            tick();
            bus.icAddrOk_i = 1'b0;
            tick();
            bus.icDataOk_i  = 1'b1;
            bus.icData_i    = data;
            bus.bpTake_i    = take;
            bus.bpDest_i    = dest;
            bus.icHasExc_i  = exc;
            bus.icExcCode_i = code;
            bus.icRefill_i  = refill;
            tick();
            bus.icDataOk_i  = 1'b0;
            bus.icHasExc_i  = 1'b0;
            bus.bpTake_i    = 4'd0;
            #1;
        end
    endtask

    logic [31:0] a;

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b0;
        bus.flush_i = 0; bus.flushTarget_i = 0; bus.stopFetch_i = 0;
        bus.icAddrOk_i = 0; bus.icDataOk_i = 0; bus.icData_i = 0;
        bus.icHasExc_i = 0; bus.icExcCode_i = 0; bus.icRefill_i = 0;
        bus.bpTake_i = 0; bus.bpDest_i = 0; bus.bpInfo_i = 32'h44332211;

        tick(); tick();
        chk("rst_req", 128'(bus.icReq_o), 128'd0);
        chk("rst_valid", 128'(bus.IF_valid_o), 128'd0);
        chk("rst_num", 128'(bus.IF_instNum_o), 128'd0);
        chk("rst_base", 128'(bus.IF_instBasePC_o), 128'd0);
        rst = 1'b1;
        #1;

        // full group from reset PC
        fetch({32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, 4'b0000, '0, 0, 0, 0, a);
        chk("t1_addr", 128'(a), 128'hBFC00000);
        chk("t1_valid", 128'(bus.IF_valid_o), 128'd1);
        chk("t1_en", 128'(bus.IF_instEnable_o), 128'hF);
        chk("t1_num", 128'(bus.IF_instNum_o), 128'd4);
        chk("t1_base", 128'(bus.IF_instBasePC_o), 128'hBFC00000);
        chk("t1_inst3", 128'(bus.IF_inst_p_o[127:96]), 128'h33333333);
        chk("t1_next", 128'(bus.icAddr_o), 128'hBFC00010);
        chk("t1_nreq", 128'(bus.icReq_o), 128'd1);

        // offset-2 fetch keeps only the upper two words
        flush_to(32'h80000008);
        fetch({32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 4'b0000, '0, 0, 0, 0, a);
        chk("t2_addr", 128'(a), 128'h80000000);
        chk("t2_en", 128'(bus.IF_instEnable_o), 128'h3);
        chk("t2_num", 128'(bus.IF_instNum_o), 128'd2);
        chk("t2_inst0", 128'(bus.IF_inst_p_o[31:0]), 128'hCCCCCCCC);
        chk("t2_inst1", 128'(bus.IF_inst_p_o[63:32]), 128'hDDDDDDDD);
        chk("t2_base", 128'(bus.IF_instBasePC_o), 128'h80000008);
        chk("t2_info0", 128'(bus.IF_predInfo_p_o[7:0]), 128'h33);
        chk("t2_next", 128'(bus.icAddr_o), 128'h80000010);

        // taken branch in slot 1 with delay slot in slot 2
        flush_to(32'h80000000);
        fetch('0, 4'b0010, {32'h0, 32'h0, 32'h80001000, 32'h0}, 0, 0, 0, a);
        chk("t3_num", 128'(bus.IF_instNum_o), 128'd3);
        chk("t3_en", 128'(bus.IF_instEnable_o), 128'h7);
        chk("t3_take", 128'(bus.IF_predTake_p_o[1:0]), 128'h2);
        chk("t3_next", 128'(bus.icAddr_o), 128'h80001000);

        // taken branch in last slot: delay slot comes from the next group
        flush_to(32'h80000000);
        fetch('0, 4'b1000, {32'h80002000, 96'h0}, 0, 0, 0, a);
        chk("t4_num1", 128'(bus.IF_instNum_o), 128'd4);
        chk("t4_next1", 128'(bus.icAddr_o), 128'h80000010);
        fetch({96'h0, 32'h5A5A5A5A}, 4'b0001, {96'h0, 32'h90000000}, 0, 0, 0, a);
        chk("t4_num2", 128'(bus.IF_instNum_o), 128'd1);
        chk("t4_en2", 128'(bus.IF_instEnable_o), 128'h1);
        chk("t4_base2", 128'(bus.IF_instBasePC_o), 128'h80000010);
        chk("t4_inst2", 128'(bus.IF_inst_p_o[31:0]), 128'h5A5A5A5A);
        chk("t4_next2", 128'(bus.icAddr_o), 128'h80002000);

        // stopFetch holds the packet and blocks requests
        flush_to(32'h80003000);
        fetch({32'h4, 32'h3, 32'h2, 32'h1}, 4'b0000, '0, 0, 0, 0, a);
        bus.stopFetch_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_valid", 128'(bus.IF_valid_o), 128'd0);
            chk("t5_req", 128'(bus.icReq_o), 128'd0);
            tick();
        end
        chk("t5_base", 128'(bus.IF_instBasePC_o), 128'h80003000);
        chk("t5_num", 128'(bus.IF_instNum_o), 128'd4);
        chk("t5_inst0", 128'(bus.IF_inst_p_o[31:0]), 128'h1);
        bus.stopFetch_i = 1'b0;
        #1;
        chk("t5_rel_valid", 128'(bus.IF_valid_o), 128'd1);
        tick();
        chk("t5_after_valid", 128'(bus.IF_valid_o), 128'd0);

        // flush while waiting: stale response is dropped
        chk("t6_req", 128'(bus.icReq_o), 128'd1);
        bus.icAddrOk_i = 1'b1;
        tick();
        bus.icAddrOk_i = 1'b0;
        bus.flush_i = 1'b1;
        bus.flushTarget_i = 32'h80004000;
        tick();
        bus.flush_i = 1'b0;
        #1;
        chk("t6_drop_req", 128'(bus.icReq_o), 128'd0);
        bus.icDataOk_i = 1'b1;
        #1;
        chk("t6_stale_valid", 128'(bus.IF_valid_o), 128'd0);
        tick();
        bus.icDataOk_i = 1'b0;
        #1;
        chk("t6_post_valid", 128'(bus.IF_valid_o), 128'd0);
        chk("t6_post_req", 128'(bus.icReq_o), 128'd1);
        chk("t6_post_addr", 128'(bus.icAddr_o), 128'h80004000);

        // misaligned PC produces an AdEL packet and halts
        flush_to(32'h80000002);
        chk("t7_req", 128'(bus.icReq_o), 128'd0);
        tick();
        chk("t7_valid", 128'(bus.IF_valid_o), 128'd1);
        chk("t7_num", 128'(bus.IF_instNum_o), 128'd1);
        chk("t7_exc", 128'(bus.IF_hasException_o), 128'd1);
        chk("t7_code", 128'(bus.IF_ExcCode_o), 128'h04);
        chk("t7_refill", 128'(bus.IF_isRefill_o), 128'd0);
        chk("t7_base", 128'(bus.IF_instBasePC_o), 128'h80000002);
        chk("t7_inst", 128'(bus.IF_inst_p_o[31:0]), 128'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t7_halt_req", 128'(bus.icReq_o), 128'd0);
            tick();
        end
        flush_to(32'h80005000);
        chk("t7_resume_req", 128'(bus.icReq_o), 128'd1);
        chk("t7_resume_addr", 128'(bus.icAddr_o), 128'h80005000);

        // translation exception on the response
        fetch('0, 4'b0000, '0, 1, 5'h03, 1, a);
        chk("t8_num", 128'(bus.IF_instNum_o), 128'd1);
        chk("t8_exc", 128'(bus.IF_hasException_o), 128'd1);
        chk("t8_code", 128'(bus.IF_ExcCode_o), 128'h03);
        chk("t8_refill", 128'(bus.IF_isRefill_o), 128'd1);
        tick();
        chk("t8_halt_req", 128'(bus.icReq_o), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
